// File: rtl/fifo_stream_pkg.sv
// Shared sizes and FSM encoding for the systolic skew-FIFO
// stream controller and its valid shadow.
package fifo_stream_pkg;

  localparam int DEPTH  = 256;
  localparam int WIDTH  = 128;
  localparam int LANES  = 16;
  localparam int LANE_W = 8;
  localparam int CNT_W  = 9;

  typedef enum logic {
    FILL,
    FLUSH
  } state_t;

endpackage

// File: rtl/fifo_stream_ctrl_valid_shadow.sv
// valid_shadow_sr: one valid bit per FIFO slot, shifted
// in lockstep with the data FIFO so the tail bit marks a real row.
module valid_shadow_sr #(
  parameter int DEPTH = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic bit_in,
  output logic tail_out
);

  logic [DEPTH-1:0] vsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsr <= '0;
    end else if (en) begin
      vsr <= {vsr[DEPTH-2:0], bit_in};
    end
  end

  assign tail_out = vsr[DEPTH-1];

endmodule

// File: rtl/fifo_stream_ctrl.sv
// fifo_stream_ctrl: drives both ends of the skew shift FIFO.
// Optional stall counter: FIFO_STREAM_CTRL_STALL_CNT_EN.
module fifo_stream_ctrl #(
  parameter int DEPTH = fifo_stream_pkg::DEPTH,
  parameter int WIDTH = fifo_stream_pkg::WIDTH,
  parameter int CNT_W = fifo_stream_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             flush_done,
  output logic             fifo_en,
  output logic [WIDTH-1:0] fifo_din,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      stall_cnt
);

  import fifo_stream_pkg::*;

  state_t state;
  logic   shift_ok;
  logic   sr_bit;
  logic   push;
  logic   pop;
  logic   empty;

  assign shift_ok = !out_valid || out_ready;
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready && fifo_en;
  assign out_data = fifo_dout;

  assign flush_done = (state == FLUSH) && empty;

  always_comb begin
    in_ready = 1'b0;
    fifo_en  = 1'b0;
    fifo_din = '0;
    sr_bit   = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = shift_ok;
        fifo_en  = in_valid && shift_ok;
        fifo_din = fifo_en ? in_data : '0;
        sr_bit   = 1'b1;
      end
      // bubbles only while something is still in flight
      FLUSH: begin
        fifo_en = shift_ok && !empty;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      count <= '0;
    end else begin
      unique case (state)
        FILL:  if (flush) state <= FLUSH;
        FLUSH: if (empty) state <= FILL;
      endcase
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  valid_shadow_sr #(
    .DEPTH(DEPTH)
  ) u_vsr (
    .clk      (clk),
    .reset    (reset),
    .en       (fifo_en),
    .bit_in   (sr_bit),
    .tail_out (out_valid)
  );

`ifdef FIFO_STREAM_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
